l2_bank_rr_arbiter: RTL and testbench

//  N-master to 1-bank round-robin arbiter for one L2 SRAM bank port in the XBAR_L2 interconnect.
//  - Selects one requesting master per cycle and forwards its request to the bank.
//  - Rotates priority after every accepted transfer (req & gnt).
//  - Routes the bank's fixed-latency response back to the master that issued the request.

---
 rtl/l2_bank_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_l2_bank_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l2_bank_rr_arbiter
// Round-robin arbiter that lets N masters share one L2 SRAM bank port. The
// master chosen each cycle has its request forwarded to the bank. Priority
// rotates past the winner after every accepted transfer. The bank's
// fixed-latency response is steered back to the master that issued it.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   data_*_i (xN)   : per-master request, address, wen (0 = write), wdata, be
//   data_gnt_o      : per-master grant (combinational)
//   data_r_valid_o  : per-master response valid (from the registered pipeline)
//   data_r_rdata_o  : bank read data, broadcast to every master
//   data_*_o (bank) : selected request payload toward the bank (combinational)
//   data_gnt_i      : bank grant
//   data_r_rdata_i  : bank read data, RESP_LAT cycles after acceptance
//   rr_ptr_o        : current highest-priority master (debug)
// ---------------------------------------------------------------------------
module l2_bank_rr_arbiter #(
    parameter  int unsigned N_MASTERS = 4,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned BE_W      = 4,
    parameter  int unsigned RESP_LAT  = 1,
    localparam int unsigned ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          data_req_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   data_add_i,
    input  logic [N_MASTERS-1:0]          data_wen_i,
    input  logic [N_MASTERS*DATA_W-1:0]   data_wdata_i,
    input  logic [N_MASTERS*BE_W-1:0]     data_be_i,
    output logic [N_MASTERS-1:0]          data_gnt_o,
    output logic [N_MASTERS-1:0]          data_r_valid_o,
    output logic [DATA_W-1:0]             data_r_rdata_o,
    output logic                          data_req_o,
    output logic [ADDR_W-1:0]             data_add_o,
    output logic                          data_wen_o,
    output logic [DATA_W-1:0]             data_wdata_o,
    output logic [BE_W-1:0]               data_be_o,
    input  logic                          data_gnt_i,
    input  logic [DATA_W-1:0]             data_r_rdata_i,
    output logic [ID_W-1:0]               rr_ptr_o
);

    logic [ID_W-1:0]                 r_ptr;
    logic [RESP_LAT-1:0]             r_vld;
    logic [RESP_LAT-1:0][ID_W-1:0]   r_id;

    logic [ID_W-1:0]                 w_winner;
    logic [ID_W-1:0]                 w_ptr_nxt;
    logic                            w_acc;

    // First requester found scanning ptr, ptr+1, ... modulo N_MASTERS.
    function automatic logic [ID_W-1:0] f_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [ID_W-1:0]      ptr);
        logic [ID_W-1:0] win;
        logic            found;
        int unsigned     idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            idx = k + 32'(ptr);
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && ((req >> idx) & N_MASTERS'(1)) != '0) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_winner   = f_pick(data_req_i, r_ptr);
    assign data_req_o = |data_req_i;
    assign w_acc      = data_req_o & data_gnt_i;
    assign w_ptr_nxt  = (w_winner == ID_W'(N_MASTERS - 1)) ? '0 : w_winner + ID_W'(1);

    // Payload mux and one-hot grant; master-0 fields when nobody requests.
    always_comb begin
        data_add_o   = data_add_i[ADDR_W-1:0];
        data_wen_o   = data_wen_i[0];
        data_wdata_o = data_wdata_i[DATA_W-1:0];
        data_be_o    = data_be_i[BE_W-1:0];
        data_gnt_o   = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (w_winner == ID_W'(i)) begin
                data_add_o    = data_add_i[i*ADDR_W +: ADDR_W];
                data_wen_o    = data_wen_i[i];
                data_wdata_o  = data_wdata_i[i*DATA_W +: DATA_W];
                data_be_o     = data_be_i[i*BE_W +: BE_W];
                // Gated by req so an idle master is never granted.
                data_gnt_o[i] = data_gnt_i & data_req_i[i];
            end
        end
    end

    // Priority pointer: advances past the winner only on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Response pipeline: {valid, id} delayed RESP_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld[0] <= w_acc;
            r_id[0]  <= w_winner;
            for (int unsigned s = 1; s < RESP_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_id[s]  <= r_id[s-1];
            end
        end
    end

    // Steer the retiring response to its issuing master.
    always_comb begin
        data_r_valid_o = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (r_id[RESP_LAT-1] == ID_W'(i)) data_r_valid_o[i] = r_vld[RESP_LAT-1];
        end
    end

    assign data_r_rdata_o = data_r_rdata_i;
    assign rr_ptr_o       = r_ptr;

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_bank_rr_arbiter
// Directed bench for l2_bank_rr_arbiter. Two instances share all inputs:
// dut_a uses RESP_LAT=1, dut_b uses RESP_LAT=3. Inputs change 1 time unit
// after a rising edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_l2_bank_rr_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [127:0]  add;
    logic [3:0]    wen;
    logic [127:0]  wdata;
    logic [15:0]   be;
    logic          gnt_i;
    logic [31:0]   rdata_i;

    logic [3:0]    gnt_a, rv_a, gnt_b, rv_b;
    logic [31:0]   rdata_a, rdata_b, add_a, add_b, wdata_a, wdata_b;
    logic          req_a, req_b, wen_a, wen_b;
    logic [3:0]    be_a, be_b;
    logic [1:0]    ptr_a, ptr_b;

    int n_vec = 0;
    int n_err = 0;

    l2_bank_rr_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .BE_W(4), .RESP_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata), .data_be_i(be),
        .data_gnt_o(gnt_a), .data_r_valid_o(rv_a), .data_r_rdata_o(rdata_a),
        .data_req_o(req_a), .data_add_o(add_a), .data_wen_o(wen_a), .data_wdata_o(wdata_a),
        .data_be_o(be_a), .data_gnt_i(gnt_i), .data_r_rdata_i(rdata_i), .rr_ptr_o(ptr_a)
    );

    l2_bank_rr_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .BE_W(4), .RESP_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata), .data_be_i(be),
        .data_gnt_o(gnt_b), .data_r_valid_o(rv_b), .data_r_rdata_o(rdata_b),
        .data_req_o(req_b), .data_add_o(add_b), .data_wen_o(wen_b), .data_wdata_o(wdata_b),
        .data_be_o(be_b), .data_gnt_i(gnt_i), .data_r_rdata_i(rdata_i), .rr_ptr_o(ptr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b1111;
        gnt_i   = 1'b0;
        wen     = 4'b1111;
        add     = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        wdata   = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        be      = {4'h8, 4'h4, 4'h2, 4'h1};
        rdata_i = 32'hCAFE_F00D;
        #2;

        // Reset with all masters requesting.
        chk("rst_rvalid_a", 128'(rv_a), 128'(4'b0000));
        chk("rst_rvalid_b", 128'(rv_b), 128'(4'b0000));
        chk("rst_ptr_a",    128'(ptr_a), 128'(2'd0));
        chk("rst_ptr_b",    128'(ptr_b), 128'(2'd0));
        chk("rst_req_o",    128'(req_a), 128'(1'b1));
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ptr", 128'(ptr_a), 128'(2'd0));
        tick();

        // Full contention: grants 0,1,2,3,0,1,2,3; RESP_LAT=1 responses lag one cycle.
        gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("cont_gnt_a",  128'(gnt_a), 128'(4'b0001 << (c % 4)));
            chk("cont_gnt_b",  128'(gnt_b), 128'(4'b0001 << (c % 4)));
            chk("cont_add",    128'(add_a), 128'(32'h0000_1000 * (c % 4)));
            chk("cont_rvalid", 128'(rv_a),  (c == 0) ? 128'(4'b0000) : 128'(4'b0001 << ((c + 3) % 4)));
            tick();
        end
        chk("cont_last_rvalid", 128'(rv_a), 128'(4'b1000));
        chk("cont_ptr_wrap",    128'(ptr_a), 128'(2'd0));

        // One accept on master 0 moves ptr to 1.
        req = 4'b0001;
        tick();
        chk("ptr_to_1", 128'(ptr_a), 128'(2'd1));

        // Skip idle: ptr=1, req=1001 -> grant 3, then 0.
        req = 4'b1001;
        #1;
        chk("skip_gnt3", 128'(gnt_a), 128'(4'b1000));
        chk("skip_be3",  128'(be_a),  128'(4'h8));
        tick();
        chk("skip_ptr0", 128'(ptr_a), 128'(2'd0));
        #1;
        chk("skip_gnt0", 128'(gnt_a), 128'(4'b0001));
        tick();
        chk("skip_ptr1", 128'(ptr_a), 128'(2'd1));

        // Idle cycle to drain the RESP_LAT=1 response.
        req   = 4'b0000;
        gnt_i = 1'b0;
        tick();

        // Bank stall: req=0110, gnt_i=0 for three cycles.
        req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_gnt",    128'(gnt_a), 128'(4'b0000));
            chk("stall_ptr",    128'(ptr_a), 128'(2'd1));
            chk("stall_rvalid", 128'(rv_a),  128'(4'b0000));
            chk("stall_add",    128'(add_a), 128'(32'h0000_1000));
            tick();
        end
        gnt_i = 1'b1;
        #1;
        chk("unstall_gnt",   128'(gnt_a),   128'(4'b0010));
        chk("unstall_wdata", 128'(wdata_a), 128'(32'hBBBB_0001));
        tick();
        chk("unstall_ptr",    128'(ptr_a), 128'(2'd2));
        chk("unstall_rvalid", 128'(rv_a),  128'(4'b0010));

        // Drain dut_b pipeline.
        req   = 4'b0000;
        gnt_i = 1'b0;
        tick();
        tick();
        tick();
        chk("drain_rvalid_b", 128'(rv_b), 128'(4'b0000));

        // Latency: RESP_LAT=3, single write from master 2.
        req   = 4'b0100;
        wen   = 4'b1011;
        gnt_i = 1'b1;
        #1;
        chk("lat_gnt",  128'(gnt_b), 128'(4'b0100));
        chk("lat_wen",  128'(wen_b), 128'(1'b0));
        tick();
        req   = 4'b0000;
        wen   = 4'b1111;
        gnt_i = 1'b0;
        chk("lat_c1", 128'(rv_b), 128'(4'b0000));
        tick();
        chk("lat_c2", 128'(rv_b), 128'(4'b0000));
        tick();
        chk("lat_c3",    128'(rv_b),    128'(4'b0100));
        chk("lat_rdata", 128'(rdata_b), 128'(32'hCAFE_F00D));
        tick();
        chk("lat_c4", 128'(rv_b), 128'(4'b0000));
        chk("lat_ptr", 128'(ptr_b), 128'(2'd3));

        // Reset mid-flight: accept on master 1 (ptr=3 scans 3,0,1), reset next cycle.
        req   = 4'b0010;
        gnt_i = 1'b1;
        #1;
        chk("mid_gnt", 128'(gnt_b), 128'(4'b0010));
        tick();
        req   = 4'b0000;
        gnt_i = 1'b0;
        rst   = 1'b1;
        #1;
        chk("mid_rst_ptr",    128'(ptr_b), 128'(2'd0));
        chk("mid_rst_rvalid", 128'(rv_b),  128'(4'b0000));
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid_no_rvalid", 128'(rv_b), 128'(4'b0000));
        end
        chk("mid_ptr_after", 128'(ptr_b), 128'(2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
